uart_rx: RTL and testbench

- Serial receiver: the stage directly downstream of the UART transmitter. Consumes its Serial_Out line.
- Deframes 10-bit frames: start bit 0, 8 data bits LSB-first, stop bit 1.
- Presents each received byte on a parallel ready/read handshake.
- Samples at mid-bit using a clock-divided bit counter.

---
 rtl/uart_rx.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchronizer, mid-bit sampling deframer and a ready/read byte handshake.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 Clk,
  input  logic                 RST,
  input  logic                 Serial_In,
  input  logic                 Rx_Read,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Rx_Ready,
  output logic                 Frame_Err,
  output logic                 Overrun,
  output logic                 Parity_Err,
  output logic                 RBusy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   sync1_q, sync2_q;
  logic                   rx_s;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   parity_err_q, parity_err_d;
`endif

  // Both stages reset to the idle (high) line level so reset never looks like a start bit.
  // NOTE: state flops use non-blocking assignments and an async reset in the sensitivity list.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= Serial_In;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      ready_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    ready_d      = ready_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    // A read only acknowledges a byte that is actually held; a good stop below may reload it.
    if (Rx_Read && ready_q) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shift_q);
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            // Unacknowledged byte is being overwritten.
            if (ready_q && !Rx_Read) begin
              overrun_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Data_Out  = data_q;
  assign Rx_Ready  = ready_q;
  assign Frame_Err = frame_err_q;
  assign Overrun   = overrun_q;
  assign RBusy     = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign Parity_Err = parity_err_q;
`else
  assign Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: latency, glitch rejection, framing error, overrun, mid-frame reset,
// and (when UART_RX_PARITY_EN is defined) parity checking.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + 10 * CPB;
`else
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;
`endif

  logic       Clk = 1'b0;
  logic       RST;
  logic       Serial_In;
  logic       Rx_Read;
  logic [7:0] Data_Out;
  logic       Rx_Ready;
  logic       Frame_Err;
  logic       Overrun;
  logic       Parity_Err;
  logic       RBusy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int last_start  = 0;
  int start_count = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .Clk       (Clk),
    .RST       (RST),
    .Serial_In (Serial_In),
    .Rx_Read   (Rx_Read),
    .Data_Out  (Data_Out),
    .Rx_Ready  (Rx_Ready),
    .Frame_Err (Frame_Err),
    .Overrun   (Overrun),
    .Parity_Err(Parity_Err),
    .RBusy     (RBusy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Error pulses are counted in cycles-high; a correct one-cycle pulse adds exactly 1.
  always @(negedge Clk) begin
    if (Frame_Err)  fe_cnt <= fe_cnt + 1;
    if (Parity_Err) pe_cnt <= pe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    Serial_In = b;
    repeat (CPB) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    last_start = cyc;
    start_count++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit) $display("note: parity bit ignored in this build");
`endif
    drive_bit(stop_bit);
  endtask

  task automatic pulse_read();
    Rx_Read = 1'b1;
    @(negedge Clk);
    Rx_Read = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_cyc;
    bit found;
    int base;
    int fe0;
    int pe0;
    int sc0;
    logic [7:0] a5;

    RST = 1'b1;
    Serial_In = 1'b1;
    Rx_Read = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_data_out", Data_Out, 8'h00);
    check("rst_rx_ready", Rx_Ready, 1'b0);
    check("rst_frame_err", Frame_Err, 1'b0);
    check("rst_overrun", Overrun, 1'b0);
    check("rst_parity_err", Parity_Err, 1'b0);
    check("rst_rbusy", RBusy, 1'b0);
    RST = 1'b0;
    repeat (4) @(negedge Clk);

    // Frame 0xDB: latency and data.
    found = 1'b0;
    rise_cyc = 0;
    fork
      send_frame(8'hDB, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge Clk);
          if (Rx_Ready) begin
            rise_cyc = cyc;
            found = 1'b1;
            break;
          end
        end
      end
    join
    check("t1_ready_rose", found, 1'b1);
    check("t1_latency_edge", rise_cyc - last_start - 1, LAT);
    check("t1_data", Data_Out, 8'hDB);
    check("t1_frame_err_cnt", fe_cnt, 0);
    check("t1_overrun", Overrun, 1'b0);
    pulse_read();
    check("t1_ready_after_read", Rx_Ready, 1'b0);
    pulse_read();
    check("t1_ready_idle_read", Rx_Ready, 1'b0);
    check("t1_data_kept", Data_Out, 8'hDB);

    // Short low glitch: rejected at the start-bit midpoint.
    base = cyc;
    fe0 = fe_cnt;
    Serial_In = 1'b0;
    repeat (4) @(negedge Clk);
    Serial_In = 1'b1;
    check("t2_busy_in_start", RBusy, 1'b1);
    repeat (8) @(negedge Clk);
    check("t2_cycle_12", cyc - base, 12);
    check("t2_busy_cleared", RBusy, 1'b0);
    check("t2_ready", Rx_Ready, 1'b0);
    check("t2_no_frame_err", fe_cnt - fe0, 0);

    // Frame 0x55 with bad stop, then a 40-cycle break.
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    Serial_In = 1'b0;
    repeat (40) @(negedge Clk);
    check("t3_busy_in_break", RBusy, 1'b1);
    check("t3_one_frame_err", fe_cnt - fe0, 1);
    check("t3_data_unchanged", Data_Out, 8'hDB);
    check("t3_ready", Rx_Ready, 1'b0);
    Serial_In = 1'b1;
    repeat (4) @(negedge Clk);
    check("t3_idle_after_high", RBusy, 1'b0);

    // Back-to-back 0x12, 0x34 with no read: overrun.
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    repeat (2) @(negedge Clk);
    check("t4_data", Data_Out, 8'h34);
    check("t4_ready", Rx_Ready, 1'b1);
    check("t4_overrun", Overrun, 1'b1);
    pulse_read();
    check("t4_ready_cleared", Rx_Ready, 1'b0);
    check("t4_overrun_cleared", Overrun, 1'b0);

    // Same pair, read coincident with the second stop sample.
    sc0 = start_count;
    found = 1'b0;
    fork
      begin
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          @(negedge Clk);
          if (start_count == sc0 + 2) break;
        end
        for (int i = 0; i < 1000; i++) begin
          if (cyc == last_start + LAT) begin
            found = 1'b1;
            break;
          end
          @(negedge Clk);
        end
        Rx_Read = 1'b1;
        @(negedge Clk);
        Rx_Read = 1'b0;
      end
    join
    repeat (2) @(negedge Clk);
    check("t4b_read_aligned", found, 1'b1);
    check("t4b_data", Data_Out, 8'h34);
    check("t4b_ready", Rx_Ready, 1'b1);
    check("t4b_no_overrun", Overrun, 1'b0);
    pulse_read();

    // Reset in the middle of the data bits of 0xA5, then frame 0x3C.
    fe0 = fe_cnt;
    a5 = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(a5[i]);
    RST = 1'b1;
    Serial_In = 1'b1;
    repeat (3) @(negedge Clk);
    check("t5_rst_busy", RBusy, 1'b0);
    check("t5_rst_data", Data_Out, 8'h00);
    RST = 1'b0;
    repeat (3) @(negedge Clk);
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (2) @(negedge Clk);
    check("t5_data", Data_Out, 8'h3C);
    check("t5_ready", Rx_Ready, 1'b1);
    check("t5_overrun", Overrun, 1'b0);
    check("t5_no_frame_err", fe_cnt - fe0, 0);
    pulse_read();

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    send_frame(8'hDB, 1'b1, 1'b0);
    repeat (2) @(negedge Clk);
    check("t6_good_parity_no_err", pe_cnt - pe0, 0);
    check("t6_good_parity_data", Data_Out, 8'hDB);
    pulse_read();
    pe0 = pe_cnt;
    send_frame(8'hDB, 1'b1, 1'b1);
    repeat (2) @(negedge Clk);
    check("t6_bad_parity_pulse", pe_cnt - pe0, 1);
    check("t6_bad_parity_data", Data_Out, 8'hDB);
    check("t6_bad_parity_ready", Rx_Ready, 1'b1);
    pulse_read();
`else
    pe0 = 0;
    check("no_parity_err_ever", pe_cnt - pe0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
